// File: rtl/tlul_uart_debug_master.sv
// tlul_uart_debug_master
// Turns a UART byte stream into single-beat 32-bit TL-UL Get/PutFullData
// requests and returns status (plus read data) as bytes.
//
// Frame from host : cmd ('R'=0x52 / 'W'=0x57), addr[7:0..31:24], (W) data[7:0..31:24]
// Reply to host   : status, (R) data[7:0..31:24]
//   status 0x00 ok, 0x01 denied, 0x02 corrupt read data,
//          0x03 misaligned address, 0xFE inter-byte timeout, 0xFF bad command
//
// Ports
//   dbg_clock_i / dbg_reset_i   clock, synchronous active-high reset
//   rx_*                        byte stream from the UART receiver FIFO
//   tx_*                        byte stream to the UART transmitter FIFO
//   dbg_a_* / dbg_d_*           TL-UL master A and D channels
//   busy_o                      high while a frame or transaction is in progress
//
// state  | meaning
// IDLE   | waiting for a command byte
// ADDR   | collecting the 4 address bytes
// DATA   | collecting the 4 write-data bytes
// REQ    | A-channel request offered, waiting for a_ready
// WAIT_D | waiting for the single outstanding D response
// RESP   | shifting reply bytes out to the tx FIFO

module tlul_uart_debug_master #(
    parameter int TL_RS     = 4,
    parameter int TL_SZ     = 4,
    parameter int AW        = 32,
    parameter int SOURCE_ID = 0,
    parameter int TIMEOUT   = 65535
) (
    input  logic             dbg_clock_i,
    input  logic             dbg_reset_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic [2:0]       dbg_a_opcode,
    output logic [2:0]       dbg_a_param,
    output logic [TL_SZ-1:0] dbg_a_size,
    output logic [TL_RS-1:0] dbg_a_source,
    output logic [AW-1:0]    dbg_a_address,
    output logic [3:0]       dbg_a_mask,
    output logic [31:0]      dbg_a_data,
    output logic             dbg_a_corrupt,
    output logic             dbg_a_valid,
    input  logic             dbg_a_ready,
    input  logic [2:0]       dbg_d_opcode,
    input  logic [1:0]       dbg_d_param,
    input  logic [TL_SZ-1:0] dbg_d_size,
    input  logic [TL_RS-1:0] dbg_d_source,
    input  logic             dbg_d_denied,
    input  logic [31:0]      dbg_d_data,
    input  logic             dbg_d_corrupt,
    input  logic             dbg_d_valid,
    output logic             dbg_d_ready,
    output logic             busy_o
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    CMD_RD  = 8'h52;
    localparam logic [7:0]    CMD_WR  = 8'h57;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_WAIT_D,
        ST_RESP
    } state_e;

    state_e        state_q;
    logic [1:0]    cnt_q;
    logic [TW-1:0] to_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          is_wr_q;
    logic [39:0]   resp_q;     // reply bytes, next byte to send in [7:0]
    logic [2:0]    left_q;     // reply bytes still to send
    logic          rx_ready_q;
    logic          tx_valid_q;
    logic          a_valid_q;
    logic          d_ready_q;

    logic          rx_fire;
    logic [7:0]    d_status;

    assign rx_fire  = rx_valid_i & rx_ready_q;
    assign d_status = dbg_d_denied                ? 8'h01 :
                      (!is_wr_q && dbg_d_corrupt) ? 8'h02 : 8'h00;

    always_ff @(posedge dbg_clock_i) begin
        if (dbg_reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            to_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            resp_q     <= '0;
            left_q     <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            a_valid_q  <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire) begin
                        if (rx_data_i == CMD_RD || rx_data_i == CMD_WR) begin
                            is_wr_q <= (rx_data_i == CMD_WR);
                            cnt_q   <= '0;
                            to_q    <= '0;
                            state_q <= ST_ADDR;
                        end else begin
                            rx_ready_q <= 1'b0;
                            resp_q     <= {32'h0, 8'hFF};
                            left_q     <= 3'd1;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_RESP;
                        end
                    end
                end

                ST_ADDR, ST_DATA: begin
                    // An accepted byte takes priority over a coinciding timeout.
                    if (rx_fire) begin
                        to_q  <= '0;
                        cnt_q <= cnt_q + 2'd1;
                        if (state_q == ST_ADDR) begin
                            addr_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
                        end else begin
                            wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
                        end
                        if (cnt_q == 2'd3) begin
                            if (state_q == ST_ADDR && is_wr_q) begin
                                state_q <= ST_DATA;
                            end else begin
                                rx_ready_q <= 1'b0;
                                // Byte 0 of the address is already stored here.
                                if (addr_q[1:0] != 2'b00) begin
                                    resp_q     <= {32'h0, 8'h03};
                                    left_q     <= 3'd1;
                                    tx_valid_q <= 1'b1;
                                    state_q    <= ST_RESP;
                                end else begin
                                    a_valid_q <= 1'b1;
                                    state_q   <= ST_REQ;
                                end
                            end
                        end
                    end else if (to_q == TO_LAST) begin
                        rx_ready_q <= 1'b0;
                        resp_q     <= {32'h0, 8'hFE};
                        left_q     <= 3'd1;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_RESP;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end

                ST_REQ: begin
                    if (dbg_a_ready) begin
                        a_valid_q <= 1'b0;
                        d_ready_q <= 1'b1;
                        state_q   <= ST_WAIT_D;
                    end
                end

                ST_WAIT_D: begin
                    if (dbg_d_valid) begin
                        d_ready_q  <= 1'b0;
                        tx_valid_q <= 1'b1;
                        if (is_wr_q) begin
                            resp_q <= {32'h0, d_status};
                            left_q <= 3'd1;
                        end else begin
                            resp_q <= {dbg_d_data, d_status};
                            left_q <= 3'd5;
                        end
                        state_q <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (tx_ready_i) begin
                        resp_q <= {8'h00, resp_q[39:8]};
                        left_q <= left_q - 3'd1;
                        if (left_q == 3'd1) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_ready_o    = rx_ready_q;
    assign tx_valid_o    = tx_valid_q;
    assign tx_data_o     = resp_q[7:0];
    assign dbg_a_opcode  = is_wr_q ? 3'd0 : 3'd4;
    assign dbg_a_param   = 3'd0;
    assign dbg_a_size    = TL_SZ'(2);
    assign dbg_a_source  = TL_RS'(SOURCE_ID);
    assign dbg_a_address = addr_q[AW-1:0];
    assign dbg_a_mask    = 4'hF;
    assign dbg_a_data    = wdata_q;
    assign dbg_a_corrupt = 1'b0;
    assign dbg_a_valid   = a_valid_q;
    assign dbg_d_ready   = d_ready_q;
    assign busy_o        = (state_q != ST_IDLE);

    // Response metadata not needed with a single outstanding transaction.
    logic unused_d;
    assign unused_d = ^{dbg_d_opcode, dbg_d_param, dbg_d_size, dbg_d_source, addr_q};

endmodule

// File: tb/tb_tlul_uart_debug_master.sv
module tb_tlul_uart_debug_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size, a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt, a_valid, a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size, d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt, d_valid, d_ready_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int a_beats = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tlul_uart_debug_master #(.TIMEOUT(TO)) dut (
        .dbg_clock_i  (clk),
        .dbg_reset_i  (rst),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready),
        .dbg_a_opcode (a_opcode),
        .dbg_a_param  (a_param),
        .dbg_a_size   (a_size),
        .dbg_a_source (a_source),
        .dbg_a_address(a_address),
        .dbg_a_mask   (a_mask),
        .dbg_a_data   (a_data),
        .dbg_a_corrupt(a_corrupt),
        .dbg_a_valid  (a_valid),
        .dbg_a_ready  (a_ready),
        .dbg_d_opcode (d_opcode),
        .dbg_d_param  (d_param),
        .dbg_d_size   (d_size),
        .dbg_d_source (d_source),
        .dbg_d_denied (d_denied),
        .dbg_d_data   (d_data),
        .dbg_d_corrupt(d_corrupt),
        .dbg_d_valid  (d_valid),
        .dbg_d_ready  (d_ready_o),
        .busy_o       (busy_o)
    );

    always @(posedge clk) if (!rst && a_valid && a_ready) a_beats <= a_beats + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the reply bytes the host should see for one frame.
    task automatic build_expected(input logic [7:0] cmd, input logic [31:0] addr,
                                  input logic den, input logic cor, input logic [31:0] rd);
        logic [7:0] st;
        exp_q.delete();
        if (cmd != 8'h52 && cmd != 8'h57) exp_q.push_back(8'hFF);
        else if (addr % 4 != 0)           exp_q.push_back(8'h03);
        else begin
            if (den)                        st = 8'h01;
            else if (cmd == 8'h52 && cor)   st = 8'h02;
            else                            st = 8'h00;
            exp_q.push_back(st);
            if (cmd == 8'h52)
                for (int i = 0; i < 4; i++) exp_q.push_back(8'((rd >> (8 * i)) & 32'hFF));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("rx_accept_wait", (n < 50), 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wd);
        send_byte(cmd);
        if (cmd == 8'h52 || cmd == 8'h57) begin
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
            if (cmd == 8'h57) for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
        end
    endtask

    task automatic check_a(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd);
        check("a_opcode", a_opcode, is_wr ? 3'd0 : 3'd4);
        check("a_address", a_address, addr);
        check("a_mask", a_mask, 4'hF);
        check("a_size", a_size, 4'd2);
        check("a_param", a_param, 3'd0);
        check("a_source", a_source, 4'd0);
        check("a_corrupt", a_corrupt, 1'b0);
        if (is_wr) check("a_data", a_data, wd);
    endtask

    task automatic do_a(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd, input int stall);
        int n = 0;
        while (a_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("a_valid_wait", (n < 50), 1);
        a_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check_a(is_wr, addr, wd);
            check("d_ready_in_req", d_ready_o, 1'b0);
            check("rx_ready_in_req", rx_ready_o, 1'b0);
            @(negedge clk);
            check("a_valid_held", a_valid, 1'b1);
        end
        a_ready = 1'b1;
        check_a(is_wr, addr, wd);
        @(negedge clk);
        a_ready = 1'b0;
        check("a_valid_drop", a_valid, 1'b0);
        check("d_ready_rise", d_ready_o, 1'b1);
    endtask

    task automatic do_d(input logic is_wr, input logic den, input logic cor, input logic [31:0] rd);
        d_opcode  = is_wr ? 3'd0 : 3'd1;
        d_param   = 2'($urandom_range(0, 3));
        d_size    = 4'd2;
        d_source  = 4'($urandom_range(0, 15));
        d_denied  = den;
        d_corrupt = cor;
        d_data    = rd;
        d_valid   = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        check("d_ready_drop", d_ready_o, 1'b0);
        check("tx_valid_rise", tx_valid_o, 1'b1);
    endtask

    task automatic recv(input int bp);
        int n;
        for (int i = 0; i < exp_q.size(); i++) begin
            n = 0;
            while (tx_valid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            check("tx_valid_wait", (n < 50), 1);
            if (i == exp_q.size() / 2) begin
                tx_ready = 1'b0;
                for (int s = 0; s < bp; s++) begin
                    check("tx_hold_data", tx_data_o, exp_q[i]);
                    check("tx_hold_valid", tx_valid_o, 1'b1);
                    @(negedge clk);
                end
            end
            tx_ready = 1'b1;
            check("tx_byte", tx_data_o, exp_q[i]);
            @(negedge clk);
            tx_ready = 1'b0;
        end
        check("tx_valid_fall", tx_valid_o, 1'b0);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wd,
                             input logic den, input logic cor, input logic [31:0] rd,
                             input int stall, input int bp);
        int   beats0 = a_beats;
        logic access = (cmd == 8'h52 || cmd == 8'h57) && (addr % 4 == 0);
        logic is_wr  = (cmd == 8'h57);
        build_expected(cmd, addr, den, cor, rd);
        send_frame(cmd, addr, wd);
        if (access) begin
            check("a_latency", a_valid, 1'b1);
            do_a(is_wr, addr, wd, stall);
            do_d(is_wr, den, cor, rd);
        end else begin
            check("no_a_valid", a_valid, 1'b0);
            check("err_tx_valid", tx_valid_o, 1'b1);
        end
        recv(bp);
        check("a_beat_count", a_beats - beats0, access ? 1 : 0);
        check("busy_idle", busy_o, 1'b0);
    endtask

    initial begin
        int beats0;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; a_ready = 1'b0;
        d_opcode = '0; d_param = '0; d_size = '0; d_source = '0; d_denied = 1'b0;
        d_data = '0; d_corrupt = 1'b0; d_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready_o, 1'b0);
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_d_ready", d_ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", rx_ready_o, 1'b1);

        run_frame(8'h57, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, 0);
        run_frame(8'h52, 32'h08, 32'h0, 0, 0, 32'h12345678, 3, 0);
        run_frame(8'h52, 32'h08, 32'h0, 1, 0, 32'hCAFEF00D, 0, 0);
        run_frame(8'h57, 32'h20, 32'h01020304, 1, 0, 32'h0, 1, 0);
        run_frame(8'h41, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
        run_frame(8'h57, 32'h44, 32'hA5A55A5A, 0, 0, 32'h0, 0, 0);
        run_frame(8'h52, 32'h00000002, 32'h0, 0, 0, 32'h0, 0, 0);
        run_frame(8'h57, 32'h00000001, 32'h11112222, 0, 0, 32'h0, 0, 0);
        run_frame(8'h52, 32'h100, 32'h0, 0, 1, 32'h89ABCDEF, 0, 10);
        run_frame(8'h57, 32'h104, 32'h55667788, 0, 1, 32'h0, 0, 2);

        // Inter-byte timeout: exactly TO idle cycles aborts the frame.
        beats0 = a_beats;
        send_byte(8'h52);
        send_byte(8'h00);
        repeat (TO - 1) @(negedge clk);
        check("to_not_yet", tx_valid_o, 1'b0);
        check("to_busy", busy_o, 1'b1);
        @(negedge clk);
        check("to_abort", tx_valid_o, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'hFE);
        recv(0);
        check("to_no_a", a_beats - beats0, 0);
        check("to_idle", busy_o, 1'b0);

        // One cycle short of the timeout: the byte wins and the read completes.
        send_byte(8'h52);
        send_byte(8'h40);
        repeat (TO - 1) @(negedge clk);
        check("to15_no_abort", tx_valid_o, 1'b0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        build_expected(8'h52, 32'h40, 0, 0, 32'h0BADBEEF);
        check("to15_a_latency", a_valid, 1'b1);
        do_a(1'b0, 32'h40, 32'h0, 0);
        do_d(1'b0, 0, 0, 32'h0BADBEEF);
        recv(0);

        // Reset while waiting on D, with a D beat arriving in the reset cycle.
        beats0 = a_beats;
        send_frame(8'h52, 32'h80, 32'h0);
        do_a(1'b0, 32'h80, 32'h0, 1);
        rst = 1'b1;
        d_valid = 1'b1; d_data = 32'h77777777; d_opcode = 3'd1;
        @(negedge clk);
        check("wrst_a_valid", a_valid, 1'b0);
        check("wrst_d_ready", d_ready_o, 1'b0);
        check("wrst_tx_valid", tx_valid_o, 1'b0);
        check("wrst_rx_ready", rx_ready_o, 1'b0);
        check("wrst_busy", busy_o, 1'b0);
        rst = 1'b0;
        d_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("wrst_no_tx", tx_valid_o, 1'b0);
            check("wrst_no_busy", busy_o, 1'b0);
        end
        check("wrst_one_beat", a_beats - beats0, 1);
        run_frame(8'h57, 32'hC0, 32'h13579BDF, 0, 0, 32'h0, 0, 0);

        // Randomized frames against the reference model.
        for (int k = 0; k < 25; k++) begin : rnd
            logic [7:0]  cmd;
            logic [31:0] addr, wd, rd;
            int          sel;
            sel  = $urandom_range(0, 9);
            addr = $urandom & 32'hFFFF_FFFC;
            wd   = $urandom;
            rd   = $urandom;
            if (sel == 0) begin
                do cmd = 8'($urandom_range(0, 255)); while (cmd == 8'h52 || cmd == 8'h57);
            end else begin
                cmd = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
                if (sel == 1) addr = addr | 32'($urandom_range(1, 3));
            end
            run_frame(cmd, addr, wd, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                      rd, $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/tlul_uart_debug_master.md
Name: tlul_uart_debug_master

Overview:
- Byte-stream-to-TileLink-UL bridge: parses command frames arriving as bytes from a UART receiver FIFO and issues single-beat 32-bit Get/PutFullData requests as a TL-UL master.
- Sends status and read data back as bytes to a UART transmitter FIFO.
- Initiator counterpart to the UART peripheral slave; lets a host debugger read and write any TL-UL slave on the bus.

Parameters:
- TL_RS, 4, A/D source field width
- TL_SZ, 4, A/D size field width
- AW, 32, A-channel address width; low AW bits of the assembled 32-bit address are used
- SOURCE_ID, 0, constant a_source value
- TIMEOUT, 65535, idle cycles allowed between bytes inside a frame (counter width: $clog2(TIMEOUT+1))

Ports:
- dbg_clock_i  in  1  clock
- dbg_reset_i  in  1  synchronous active-high reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx byte available
- rx_ready_o  out  1  byte consumed this cycle when rx_valid_i&rx_ready_o
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx byte offered
- tx_ready_i  in  1  tx FIFO accepts
- dbg_a_opcode  out  3  4=Get, 0=PutFullData
- dbg_a_param  out  3  always 0
- dbg_a_size  out  TL_SZ  always 2
- dbg_a_source  out  TL_RS  SOURCE_ID
- dbg_a_address  out  AW  request address
- dbg_a_mask  out  4  always 4'hF
- dbg_a_data  out  32  write data
- dbg_a_corrupt  out  1  always 0
- dbg_a_valid  out  1  request valid
- dbg_a_ready  in  1  slave accepts
- dbg_d_opcode  in  3  1=AccessAckData, 0=AccessAck
- dbg_d_param  in  2  ignored
- dbg_d_size  in  TL_SZ  ignored
- dbg_d_source  in  TL_RS  ignored (one outstanding)
- dbg_d_denied  in  1  error
- dbg_d_data  in  32  read data
- dbg_d_corrupt  in  1  data corrupt
- dbg_d_valid  in  1  response valid
- dbg_d_ready  out  1  response accepted
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous and active-high on dbg_reset_i. Reset values: state IDLE, dbg_a_valid=0, dbg_d_ready=0, tx_valid_o=0, rx_ready_o=0, busy_o=0, byte counters=0, timeout counter=0. Reset mid-frame or mid-transaction discards everything, including an outstanding D response.
- Frame format: cmd byte, then 4 address bytes little-endian, then for writes 4 data bytes little-endian. 0x52 ('R') = read, 0x57 ('W') = write.
- IDLE: rx_ready_o=1. A byte of 0x52 or 0x57 goes to ADDR with cnt=0. Any other byte loads status 0xFF and goes to RESP with length 1.
- ADDR: rx_ready_o=1. Each accepted byte goes to addr[8*cnt+:8]. After cnt==3, a read goes to REQ and a write goes to DATA with cnt=0.
- DATA: rx_ready_o=1. Same as ADDR into wdata. After cnt==3, go to REQ.
- Alignment check on entry to REQ: if addr[1:0]!=0, issue no bus access; status 0x03, RESP length 1.
- REQ: dbg_a_valid=1 with all A fields stable until dbg_a_valid&dbg_a_ready, then go to WAIT_D. rx_ready_o=0 from REQ through RESP.
- Minimum latency: dbg_a_valid is asserted the cycle after the last frame byte is accepted.
- WAIT_D: dbg_d_ready=1 and dbg_a_valid=0. On dbg_d_valid, capture the response.
  - status = 0x01 if denied; else 0x02 if corrupt on a read; else 0x00.
  - Read frame: resp = {status, d_data[7:0], [15:8], [23:16], [31:24]}, length 5. The data bytes are sent even if status is nonzero.
  - Write frame: length 1.
  - Go to RESP.
- RESP: tx_valid_o=1 with tx_data_o = current byte, held until tx_ready_i. After the last byte is taken, go to IDLE. tx_valid_o falls the cycle after the final handshake.
- Inter-byte timeout: in ADDR/DATA, the counter increments each cycle without an accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT aborts the frame: status 0xFE, RESP length 1.
  - If an accepted byte and the timeout coincide, the byte wins.
- No D-channel timeout. Exactly one transaction is outstanding at a time. A D beat arriving outside WAIT_D is never acknowledged (dbg_d_ready=0).
- The A-channel handshake and the last rx byte can never occur in the same cycle; a frame is fully received before A is raised.

Test Plan:
- Write: bytes 57 10 00 00 00 EF BE AD DE, slave ready -> one A beat with opcode 0, addr 0x10, data 0xDEADBEEF, mask F, size 2; AccessAck -> tx byte 00.
- Read: 52 08 00 00 00; slave returns d_data 0x12345678 with a 3-cycle a_ready stall -> A fields held stable during the stall; tx bytes 00 78 56 34 12.
- Denied read: d_denied=1 -> tx 01 followed by 4 data bytes. Denied write -> tx 01 only.
- Bad command byte 0x41 -> tx FF, no A beat, next valid frame still works. Misaligned address 0x00000002 -> tx 03, no A beat.
- Timeout (TIMEOUT=16): send 52 00, then stall 16 cycles -> tx FE, return to IDLE. Stall 15 cycles, then continue -> normal read.
- Backpressure and reset: tx_ready_i low for 10 cycles during a 5-byte response -> tx_data_o stable, no bytes lost. Assert dbg_reset_i in WAIT_D -> all outputs at reset values the next cycle, no tx output.
